// File: rtl/wb_pkg.sv
// Shared types for the dual-lane MEM/WB writeback stage.
// Lane entries, load-type encodings and datapath widths.
package wb_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 32;

    typedef enum logic [2:0] {
        LT_NONE = 3'd0,
        LT_LB   = 3'd1,
        LT_LBU  = 3'd2,
        LT_LH   = 3'd3,
        LT_LHU  = 3'd4,
        LT_LW   = 3'd5
    } ld_type_e;

    typedef struct packed {
        logic              valid;
        logic              wen;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] result;
        ld_type_e          ldtype;
        logic [DATA_W-1:0] ldraw;
        logic [1:0]        boff;
        logic [31:0]       pc;
    } wb_entry_t;

endpackage

// File: rtl/wb_dual_stage_if.sv
// MEM-side capture bus and register-file write bus of the WB stage.
// master = MEM/regfile side, slave = the WB stage itself.
interface wb_dual_stage_if;
    import wb_pkg::*;

    logic              m_valid_1;
    logic              m_valid_2;
    logic              m_wen_1;
    logic              m_wen_2;
    logic [ADDR_W-1:0] m_waddr_1;
    logic [ADDR_W-1:0] m_waddr_2;
    logic [DATA_W-1:0] m_result_1;
    logic [DATA_W-1:0] m_result_2;
    logic [2:0]        m_ldtype_1;
    logic [2:0]        m_ldtype_2;
    logic [DATA_W-1:0] m_ldraw_1;
    logic [DATA_W-1:0] m_ldraw_2;
    logic [1:0]        m_boff_1;
    logic [1:0]        m_boff_2;
    logic [31:0]       m_pc_1;
    logic [31:0]       m_pc_2;

    logic              w_ena;
    logic [ADDR_W-1:0] w_addr_1;
    logic [ADDR_W-1:0] w_addr_2;
    logic [DATA_W-1:0] w_data_1;
    logic [DATA_W-1:0] w_data_2;
    logic              wb_valid_1;
    logic              wb_valid_2;
    logic [31:0]       wb_pc_1;
    logic [31:0]       wb_pc_2;

    modport master (
        output m_valid_1, m_valid_2, m_wen_1, m_wen_2,
        output m_waddr_1, m_waddr_2, m_result_1, m_result_2,
        output m_ldtype_1, m_ldtype_2, m_ldraw_1, m_ldraw_2,
        output m_boff_1, m_boff_2, m_pc_1, m_pc_2,
        input  w_ena, w_addr_1, w_addr_2, w_data_1, w_data_2,
        input  wb_valid_1, wb_valid_2, wb_pc_1, wb_pc_2
    );

    modport slave (
        input  m_valid_1, m_valid_2, m_wen_1, m_wen_2,
        input  m_waddr_1, m_waddr_2, m_result_1, m_result_2,
        input  m_ldtype_1, m_ldtype_2, m_ldraw_1, m_ldraw_2,
        input  m_boff_1, m_boff_2, m_pc_1, m_pc_2,
        output w_ena, w_addr_1, w_addr_2, w_data_1, w_data_2,
        output wb_valid_1, wb_valid_2, wb_pc_1, wb_pc_2
    );

endinterface

// File: rtl/wb_load_fmt.sv
// Load-data formatter: picks byte/half/word from the raw aligned word
// and extends it; non-loads (and reserved encodings) pass result.
module wb_load_fmt
    import wb_pkg::*;
(
    input  ld_type_e          ldtype,
    input  logic [DATA_W-1:0] ldraw,
    input  logic [1:0]        boff,
    input  logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Little-endian lane select; boff[0] is ignored for halfwords.
    always_comb begin
        byte_sel = ldraw[7:0];
        unique case (boff)
            2'd0: byte_sel = ldraw[7:0];
            2'd1: byte_sel = ldraw[15:8];
            2'd2: byte_sel = ldraw[23:16];
            2'd3: byte_sel = ldraw[31:24];
        endcase
        half_sel = boff[1] ? ldraw[31:16] : ldraw[15:0];
    end

    // Extension per load type; anything unrecognised behaves as a non-load.
    always_comb begin
        data = result;
        case (ldtype)
            LT_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  data = {24'd0, byte_sel};
            LT_LH:   data = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  data = {16'd0, half_sel};
            LT_LW:   data = ldraw;
            default: data = result;
        endcase
    end

endmodule

// File: rtl/wb_dual_stage.sv
// Dual-lane MEM/WB register and writeback formatter feeding the
// register file, plus the retired-instruction counter.
module wb_dual_stage
    import wb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_stall,
    input  logic             wb_flush,
    wb_dual_stage_if.slave   bus,
    output logic [CNT_W-1:0] retire_cnt
);

    wb_entry_t        e1_q;
    wb_entry_t        e2_q;
    wb_entry_t        e1_d;
    wb_entry_t        e2_d;
    logic [CNT_W-1:0] cnt_q;
    logic             we_1;
    logic             we_2;
    logic [DATA_W-1:0] fmt_1;
    logic [DATA_W-1:0] fmt_2;

    // Next entry: a bubble keeps every payload field, only valids drop.
    always_comb begin
        e1_d = e1_q;
        e2_d = e2_q;
        if (wb_flush || mem_stall) begin
            e1_d.valid = 1'b0;
            e2_d.valid = 1'b0;
        end else begin
            e1_d.valid  = bus.m_valid_1;
            e1_d.wen    = bus.m_wen_1;
            e1_d.waddr  = bus.m_waddr_1;
            e1_d.result = bus.m_result_1;
            e1_d.ldtype = ld_type_e'(bus.m_ldtype_1);
            e1_d.ldraw  = bus.m_ldraw_1;
            e1_d.boff   = bus.m_boff_1;
            e1_d.pc     = bus.m_pc_1;
            e2_d.valid  = bus.m_valid_2;
            e2_d.wen    = bus.m_wen_2;
            e2_d.waddr  = bus.m_waddr_2;
            e2_d.result = bus.m_result_2;
            e2_d.ldtype = ld_type_e'(bus.m_ldtype_2);
            e2_d.ldraw  = bus.m_ldraw_2;
            e2_d.boff   = bus.m_boff_2;
            e2_d.pc     = bus.m_pc_2;
        end
    end

    // Entry register; the counter adds the entry held during this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e1_q  <= '0;
            e2_q  <= '0;
            cnt_q <= '0;
        end else begin
            e1_q  <= e1_d;
            e2_q  <= e2_d;
            cnt_q <= cnt_q + CNT_W'(e1_q.valid) + CNT_W'(e2_q.valid);
        end
    end

    wb_load_fmt u_fmt_1 (
        .ldtype (e1_q.ldtype),
        .ldraw  (e1_q.ldraw),
        .boff   (e1_q.boff),
        .result (e1_q.result),
        .data   (fmt_1)
    );

    wb_load_fmt u_fmt_2 (
        .ldtype (e2_q.ldtype),
        .ldraw  (e2_q.ldraw),
        .boff   (e2_q.boff),
        .result (e2_q.result),
        .data   (fmt_2)
    );

    // Write qualify: squashed lanes aim at r0 with zero data.
    always_comb begin
        we_1         = e1_q.valid & e1_q.wen;
        we_2         = e2_q.valid & e2_q.wen;
        bus.w_ena    = we_1 | we_2;
        bus.w_addr_1 = we_1 ? e1_q.waddr : '0;
        bus.w_addr_2 = we_2 ? e2_q.waddr : '0;
        bus.w_data_1 = we_1 ? fmt_1 : '0;
        bus.w_data_2 = we_2 ? fmt_2 : '0;
        bus.wb_valid_1 = e1_q.valid;
        bus.wb_valid_2 = e2_q.valid;
        bus.wb_pc_1    = e1_q.pc;
        bus.wb_pc_2    = e2_q.pc;
    end

    assign retire_cnt = cnt_q;

endmodule
